pipe_stage: RTL

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_stall_counter.sv | 19 +
 rtl/pipe_stage.sv | 96 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipe_stage skid-buffered register slice.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int CNT_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter used for downstream stall statistics.
module pipe_stall_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Two-entry skid-buffered pipeline register with registered ready/valid.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt_o stall-cycle counter.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter int               CNT_WIDTH     = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic [WIDTH-1:0]     value_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [WIDTH-1:0]     value_o,
  input  logic                 ready_i
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
`endif
);

  pipe_state_e      state_q;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             accept, transfer;

  assign accept   = valid_i && ready_o;
  assign transfer = valid_o && ready_i;
  assign value_o  = main_q;

  // ready_o/valid_o are kept as flops alongside state so neither depends on ready_i.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= EMPTY;
      main_q  <= INITIAL_VALUE;
      skid_q  <= INITIAL_VALUE;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else if (flush_i) begin
      state_q <= EMPTY;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= value_i;
            state_q <= ONE;
            valid_o <= 1'b1;
          end
        end
        ONE: begin
          if (accept && transfer) begin
            main_q <= value_i;
          end else if (accept) begin
            skid_q  <= value_i;
            state_q <= TWO;
            ready_o <= 1'b0;
          end else if (transfer) begin
            state_q <= EMPTY;
            valid_o <= 1'b0;
          end
        end
        TWO: begin
          if (transfer) begin
            main_q  <= skid_q;
            state_q <= ONE;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_stall_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .inc_i   (valid_o && !ready_i),
    .cnt_o   (stall_cnt_o)
  );
`else
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule
